// File: rtl/clk_rst_pkg.sv
// -----------------------------------------------------------------------------
// clk_rst_pkg
// Shared clock/reset definitions: the reset-sequencer FSM state type and the
// default timing constants used by pll_reset_seq.
// -----------------------------------------------------------------------------
package clk_rst_pkg;

    // Reset sequencer states, in the order the sequence walks through them.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } rstseq_state_t;

    localparam int RSTSEQ_SYNC_STAGES_DEF   = 2;
    localparam int RSTSEQ_STABLE_CYCLES_DEF = 1024;
    localparam int RSTSEQ_HOLD_CYCLES_DEF   = 16;

endpackage

// File: rtl/sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
// Parameterised N-flop single-bit synchroniser with asynchronous active-low
// reset. Used for the PLL lock input here and for button / UART RX inputs
// elsewhere.
//
// Parameters:
//   STAGES  - number of flops in the chain (minimum 2)
//   RST_VAL - value loaded into every flop while rst_n is low
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset
//   d     - asynchronous input bit
//   q     - synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_bit #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {STAGES{RST_VAL}};
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
// Reset sequencer driven by the PLL lock indicator and clocked by the PLL
// output clock. The lock signal is synchronised, must stay high for
// STABLE_CYCLES, then the system reset is held for HOLD_CYCLES more before
// being released. Losing lock while running re-asserts reset at once and is
// recorded in a sticky flag and a saturating counter.
//
// Build option:
//   PLL_RSTSEQ_LOSS_CNT_EN - when defined, loss_count counts lock-loss events
//                            (saturating). When undefined, the counter is
//                            not built and loss_count is tied to 0.
//
// Parameters:
//   SYNC_STAGES   - flops in the locked synchroniser (>= 2)
//   STABLE_CYCLES - consecutive high cycles of locked_s before HOLD (>= 1)
//   HOLD_CYCLES   - cycles reset stays asserted after the stable interval (>= 1)
//   CNT_W         - width of loss_count
// Ports:
//   clock_in    - PLL output clock (single clock domain)
//   reset_n     - asynchronous active-low reset (power-on / button)
//   locked      - PLL lock, asynchronous to clock_in
//   clear_lost  - single-cycle pulse clearing lock_lost
//   sys_reset_n - registered active-low system reset, high only in RUN
//   ready       - registered, high only in RUN
//   lock_lost   - sticky flag, set when lock drops in RUN
//   loss_count  - saturating count of lock drops in RUN
// -----------------------------------------------------------------------------
module pll_reset_seq
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES   = RSTSEQ_SYNC_STAGES_DEF,
    parameter int STABLE_CYCLES = RSTSEQ_STABLE_CYCLES_DEF,
    parameter int HOLD_CYCLES   = RSTSEQ_HOLD_CYCLES_DEF,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             locked,
    input  logic             clear_lost,
    output logic             sys_reset_n,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] loss_count
);

    // The interval counter only needs to reach max(STABLE, HOLD) - 1.
    localparam int MAX_IVL = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int IVL_W   = (MAX_IVL > 1) ? $clog2(MAX_IVL) : 1;

    localparam logic [IVL_W-1:0] STABLE_LAST = IVL_W'(STABLE_CYCLES - 1);
    localparam logic [IVL_W-1:0] HOLD_LAST   = IVL_W'(HOLD_CYCLES - 1);

    logic          w_locked_s;
    rstseq_state_t r_state;
    rstseq_state_t w_state_nxt;
    logic [IVL_W-1:0] r_ivl_cnt;
    logic          w_loss_evt;
    logic          r_sys_reset_n;
    logic          r_ready;
    logic          r_lock_lost;

    sync_bit #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (locked),
        .q     (w_locked_s)
    );

    // Next-state logic. Only a drop while in RUN counts as a loss event;
    // drops during STABLE/HOLD simply restart the sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_loss_evt  = 1'b0;
        unique case (r_state)
            WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = STABLE;
                end
            end
            STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_ivl_cnt == STABLE_LAST) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                end else if (r_ivl_cnt == HOLD_LAST) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_locked_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_loss_evt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = WAIT_LOCK;
            end
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= WAIT_LOCK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Interval counter: cleared on every state change, counts only in the
    // timed states so it never has to wrap.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_ivl_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_ivl_cnt <= '0;
        end else if ((r_state == STABLE) || (r_state == HOLD)) begin
            r_ivl_cnt <= r_ivl_cnt + IVL_W'(1);
        end
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state and come straight from a flop (glitch-free reset).
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_sys_reset_n <= 1'b0;
            r_ready       <= 1'b0;
        end else begin
            r_sys_reset_n <= (w_state_nxt == RUN);
            r_ready       <= (w_state_nxt == RUN);
        end
    end

    // Sticky loss flag; a loss in the same cycle as a clear wins.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_lost <= 1'b0;
        end else if (w_loss_evt) begin
            r_lock_lost <= 1'b1;
        end else if (clear_lost) begin
            r_lock_lost <= 1'b0;
        end
    end

`ifdef PLL_RSTSEQ_LOSS_CNT_EN
    logic [CNT_W-1:0] r_loss_cnt;

    // Saturating loss counter; clear_lost deliberately leaves it alone.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != {CNT_W{1'b1}})) begin
            r_loss_cnt <= r_loss_cnt + CNT_W'(1);
        end
    end

    assign loss_count = r_loss_cnt;
`else
    assign loss_count = '0;
`endif

    assign sys_reset_n = r_sys_reset_n;
    assign ready       = r_ready;
    assign lock_lost   = r_lock_lost;

endmodule
